fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Port: clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: npc  input  32  next PC from the sequencer, either the branch target or notbranch.
REQ-005 Port: npc_valid  input  1  one-cycle strobe: the current instruction has resolved and npc is valid.
REQ-006 Port: imem_req  output  1  instruction memory read request.
REQ-007 Port: imem_addr  output  32  instruction memory word address.
REQ-008 Port: imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-009 Port: imem_rdata  input  32  instruction word returned by memory.
REQ-010 Port: pc  output  32  PC of the instruction currently held.
REQ-011 Port: notbranch  output  32  pc+4, fed to the sequencer notbranch input.
REQ-012 Port: inst  output  32  latched instruction word.
REQ-013 Port: inst_valid  output  1  inst and pc are valid for decode and execute.
REQ-014 Port: fetch_err  output  1  a misaligned npc has been received; fetching is halted.
REQ-015 Port: instret  output  32  count of retired instructions (accepted npc_valid strobes).

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, HOLD and ERR.
REQ-017 IDLE SHALL move to FETCH unconditionally on the next clk edge.
REQ-018 FETCH SHALL drive imem_req=1 and SHALL hold imem_addr=pc stable until imem_ack is seen.
REQ-019 In FETCH with imem_ack=1 at a clk edge, the block SHALL set inst<=imem_rdata and move to HOLD; acks in the same cycle as the request are legal, giving a minimum of 1 cycle from FETCH entry to inst_valid.
REQ-020 In FETCH with imem_ack=0, the block SHALL remain in FETCH; wait states are unbounded.
REQ-021 imem_req SHALL be 1 only in FETCH; imem_ack SHALL be ignored in every other state.
REQ-022 inst_valid SHALL equal (state==HOLD); inst SHALL remain unchanged until the next accepted ack.
REQ-023 In HOLD with npc_valid=1 and npc[1:0]==2'b00, the block SHALL set pc<=npc, increment instret, and move to FETCH.
REQ-024 In HOLD with npc_valid=1 and npc[1:0]!=2'b00, the block SHALL move to ERR, leave pc unchanged, and leave instret unchanged.
REQ-025 npc_valid SHALL be ignored outside HOLD.
REQ-026 In ERR, fetch_err SHALL be 1, imem_req SHALL be 0, and the state SHALL remain ERR until rst.
REQ-027 notbranch SHALL be combinational pc+32'd4, modulo 2^32 (0xFFFFFFFC yields 0x00000000).
REQ-028 instret SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-029 imem_addr SHALL equal pc in all states.

Reset
REQ-030 While rst=1, the block SHALL immediately force state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (NOP), instret=0, imem_req=0, inst_valid=0 and fetch_err=0.
REQ-031 Reset asserted mid-FETCH SHALL drop imem_req the same instant; a late imem_ack after reset release SHALL be ignored while in IDLE.
REQ-032 After rst deasserts, the first imem_req=1 SHALL appear after exactly one clk edge (IDLE -> FETCH).

Verification
REQ-033 Release rst with imem_ack tied to 1 and imem_rdata=0x00500093 -> edge 1: imem_req=1, addr=0x0; edge 2: inst_valid=1, inst=0x00500093, pc=0, notbranch=4.
REQ-034 In HOLD, npc=0xAABBCCDC with npc_valid=1 -> next cycle pc=0xAABBCCDC, imem_req=1, imem_addr=0xAABBCCDC, notbranch=0xAABBCCE0, instret=1, inst_valid=0.
REQ-035 Hold imem_ack=0 for 3 cycles in FETCH -> imem_req=1 and addr stable throughout, inst_valid=0; ack on the 4th cycle -> inst_valid=1 on the following cycle.
REQ-036 In HOLD, npc=0xDDCCBBAA with npc_valid=1 -> fetch_err=1, imem_req=0, pc and instret unchanged, persisting for 10 cycles and later acks ignored; then rst -> fetch_err=0, pc=RESET_PC.
REQ-037 Assert rst while imem_req=1 at addr 0x100, then pulse imem_ack in IDLE after release -> imem_req=0 immediately, pc=RESET_PC, inst=0x00000013, and the ack produces no inst_valid.
REQ-038 In HOLD, npc=0xFFFFFFFC with npc_valid=1 -> pc=0xFFFFFFFC, notbranch=0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at pc, holds it for decode/execute,
// then redirects to the sequencer's npc. A misaligned npc parks the unit in ERR until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] notbranch,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fetch_err,
    output logic [31:0] instret
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] instret_q;
    logic        req_q;
    logic        vld_q;
    logic        err_q;

    // Status outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= NOP;
            instret_q <= '0;
            req_q     <= 1'b0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        inst_q  <= imem_rdata;
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                        vld_q   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (npc_valid) begin
                        vld_q <= 1'b0;
                        if (npc[1:0] == 2'b00) begin
                            pc_q      <= npc;
                            instret_q <= instret_q + 32'd1;
                            state_q   <= FETCH;
                            req_q     <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    vld_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign notbranch  = pc_q + 32'd4;
    assign inst       = inst_q;
    assign inst_valid = vld_q;
    assign fetch_err  = err_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// traffic, all compared against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        npc_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] notbranch;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;
    logic [31:0] instret;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .npc_valid  (npc_valid),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .notbranch  (notbranch),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // Reference model: what the unit is doing, not how it encodes it.
    bit          m_started;   // one edge has passed since reset release
    bit          m_waiting;   // a memory read is outstanding
    bit          m_have;      // an instruction is held for the sequencer
    bit          m_halted;    // a misaligned redirect was seen
    logic [31:0] m_pc, m_inst, m_instret;

    task automatic model_reset();
        m_started = 0; m_waiting = 0; m_have = 0; m_halted = 0;
        m_pc = RESET_PC; m_inst = NOP; m_instret = 0;
    endtask

    task automatic model_edge();
        if (rst) model_reset();
        else if (m_halted) ;
        else if (!m_started) begin
            m_started = 1; m_waiting = 1;
        end else if (m_waiting) begin
            if (imem_ack) begin
                m_inst = imem_rdata; m_waiting = 0; m_have = 1;
            end
        end else if (m_have && npc_valid) begin
            m_have = 0;
            if (npc % 4 == 0) begin
                m_pc = npc; m_instret = m_instret + 1; m_waiting = 1;
            end else m_halted = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},       32'(imem_req),   32'(m_waiting && !m_halted));
        chk({tag, ".addr"},      imem_addr,       m_pc);
        chk({tag, ".pc"},        pc,              m_pc);
        chk({tag, ".notbranch"}, notbranch,       m_pc + 32'd4);
        chk({tag, ".inst"},      inst,            m_inst);
        chk({tag, ".inst_vld"},  32'(inst_valid), 32'(m_have));
        chk({tag, ".err"},       32'(fetch_err),  32'(m_halted));
        chk({tag, ".instret"},   instret,         m_instret);
    endtask

    // Inputs change only after the falling edge; outputs are sampled there too.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst = 1; npc = 0; npc_valid = 0; imem_ack = 0; imem_rdata = 0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        cycle("reset_hold");

        // Ack tied high straight out of reset: one edge to request, one to hold.
        rst = 0; imem_ack = 1; imem_rdata = 32'h0050_0093;
        cycle("boot_e1");
        chk("boot_e1_req", 32'(imem_req), 32'd1);
        cycle("boot_e2");
        chk("boot_e2_inst", inst, 32'h0050_0093);
        chk("boot_e2_nb", notbranch, 32'd4);

        imem_ack = 0; npc = 32'hAABB_CCDC; npc_valid = 1;
        cycle("redir");
        npc_valid = 0;
        chk("redir_pc", pc, 32'hAABB_CCDC);
        chk("redir_nb", notbranch, 32'hAABB_CCE0);
        chk("redir_instret", instret, 32'd1);

        for (int i = 0; i < 3; i++) begin
            cycle("wait");
            chk("wait_addr", imem_addr, 32'hAABB_CCDC);
        end
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        cycle("late_ack");
        chk("late_ack_vld", 32'(inst_valid), 32'd1);

        imem_ack = 0; npc = 32'hFFFF_FFFC; npc_valid = 1;
        cycle("top_pc");
        npc_valid = 0;
        chk("top_pc_nb", notbranch, 32'h0000_0000);
        imem_ack = 1;
        cycle("top_pc_fetch");

        npc = 32'hDDCC_BBAA; npc_valid = 1;
        cycle("misalign");
        npc_valid = 0; imem_rdata = 32'h1234_5678;
        chk("misalign_err", 32'(fetch_err), 32'd1);
        for (int i = 0; i < 10; i++) cycle("halted");
        rst = 1;
        cycle("err_rst");
        chk("err_rst_pc", pc, RESET_PC);

        // Reach FETCH at 0x100, then reset between edges.
        rst = 0; imem_ack = 1;
        cycle("r37_a");
        cycle("r37_b");
        imem_ack = 0; npc = 32'h0000_0100; npc_valid = 1;
        cycle("r37_c");
        npc_valid = 0;
        chk("r37_fetch_addr", imem_addr, 32'h100);
        #2 rst = 1;
        #1 model_reset();
        check_all("async_rst");
        chk("async_rst_inst", inst, NOP);
        cycle("async_rst_hold");
        rst = 0; imem_ack = 1;
        cycle("idle_ack");
        imem_ack = 0;
        cycle("idle_ack_after");
        chk("idle_ack_novld", 32'(inst_valid), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            imem_ack   = ($urandom % 3) != 0;
            imem_rdata = $urandom;
            npc_valid  = $urandom % 2;
            npc        = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 50 == 0) npc[1:0] = 2'($urandom_range(1, 3));
            rst = ($urandom % 300 == 0) || (m_halted && $urandom % 8 == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
